// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Multicycle instruction-fetch sequencer for the 8080 core. Owns the program
//   counter, issues one memory read per instruction, decodes the instruction
//   length from the opcode and presents the assembled instruction to decode.
//   Control-flow redirects from execute and HLT are handled here.
//
// Parameters
//   RESET_PC     PC value loaded on reset.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   mem_req      read request for the current cycle (FETCH state)
//   mem_addr     read address, always the PC register
//   mem_data     read data {opcode, low byte, high byte}, valid the cycle after mem_req
//   dec_valid    instruction available to decode
//   dec_ready    decode accepts the instruction
//   dec_instr    captured instruction, same byte layout as mem_data
//   dec_len      instruction length (1, 2 or 3)
//   dec_pc       address of dec_instr
//   redir_valid  control-flow redirect request
//   redir_pc     redirect target
//   halted       core halted by HLT
//   perf_count   retired-instruction count (only with FETCH_PERF_EN)
//
// Optional feature
//   FETCH_PERF_EN  when defined, adds the perf_count port and its counter.
//
// Handshake: an instruction transfers to decode on any rising clock edge where
// dec_valid and dec_ready are both high. Once dec_valid rises, dec_instr,
// dec_len and dec_pc hold steady until that transfer. dec_valid is masked by
// redir_valid, so a redirect cycle never transfers an instruction.

module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [23:0] mem_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [23:0] dec_instr,
    output logic [1:0]  dec_len,
    output logic [15:0] dec_pc,
    input  logic        redir_valid,
    input  logic [15:0] redir_pc,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [7:0] OP_HLT = 8'h76;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc;
    logic [15:0] pc_nxt;
    logic        capture;
    logic        handshake;

    // Instruction length from the opcode alone.
    function automatic logic [1:0] decode_len(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd1;
        if (((op & 8'hCF) == 8'h01) ||              // LXI rp
            (op == 8'h22) || (op == 8'h2A) ||
            (op == 8'h32) || (op == 8'h3A) ||
            (op == 8'hC3) || (op == 8'hCB) ||
            ((op & 8'hC7) == 8'hC2) ||              // Jccc
            ((op & 8'hC7) == 8'hC4) ||              // Cccc
            (op == 8'hCD) || (op == 8'hDD) ||
            (op == 8'hED) || (op == 8'hFD)) begin
            len = 2'd3;
        end else if (((op & 8'hC7) == 8'h06) ||     // MVI r
                     (op == 8'hC6) || (op == 8'hCE) ||
                     (op == 8'hD6) || (op == 8'hDE) ||
                     (op == 8'hE6) || (op == 8'hEE) ||
                     (op == 8'hF6) || (op == 8'hFE) ||
                     (op == 8'hD3) || (op == 8'hDB)) begin
            len = 2'd2;
        end
        return len;
    endfunction

    // Outputs depend only on state and registers, except dec_valid which is
    // also masked by a same-cycle redirect.
    assign mem_req   = (state == S_FETCH);
    assign mem_addr  = pc;
    assign dec_valid = (state == S_HOLD) && !redir_valid;
    assign halted    = (state == S_HALTED);
    assign handshake = dec_valid && dec_ready;

    // Next-state and PC logic. Redirect overrides every other transition.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        if (redir_valid) begin
            state_nxt = S_FETCH;
            pc_nxt    = redir_pc;
        end else begin
            case (state)
                S_IDLE: begin
                    state_nxt = S_FETCH;
                end
                S_FETCH: begin
                    state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    // Only here is mem_data taken, so a response belonging to
                    // a request issued before a redirect is never captured.
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
                S_HOLD: begin
                    if (handshake) begin
                        if (dec_instr[23:16] == OP_HLT) begin
                            state_nxt = S_HALTED;
                        end else begin
                            pc_nxt    = pc + {14'd0, dec_len};
                            state_nxt = S_FETCH;
                        end
                    end
                end
                S_HALTED: begin
                    state_nxt = S_HALTED;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_instr <= 24'd0;
            dec_len   <= 2'd1;
            dec_pc    <= 16'd0;
        end else if (capture) begin
            dec_instr <= mem_data;
            dec_len   <= decode_len(mem_data[23:16]);
            dec_pc    <= pc;
        end
    end

`ifdef FETCH_PERF_EN
    // Counts every transfer to decode, HLT included; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_count <= 32'd0;
        end else if (handshake) begin
            perf_count <= perf_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [23:0] mem_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [23:0] dec_instr;
    logic [1:0]  dec_len;
    logic [15:0] dec_pc;
    logic        redir_valid;
    logic [15:0] redir_pc;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_count;
`endif

    int errors;
    int checks;

    logic [7:0] mem_b [0:65535];

    fetch_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_len     (dec_len),
        .dec_pc      (dec_pc),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .halted      (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_count  (perf_count)
`endif
    );

    // clock block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory responder: data for a request appears in the following cycle
    always @(posedge clk) begin
        if (mem_req) begin
            mem_data <= {mem_b[mem_addr], mem_b[mem_addr + 16'd1], mem_b[mem_addr + 16'd2]};
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem_b[i] = 8'h00;
    endtask

    // Leaves the bench at a negedge with reset released; the next posedge is edge 1.
    task automatic do_reset();
        rst_n       = 1'b0;
        dec_ready   = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        dec_ready   = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 16'h0000 || dec_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got req=%b addr=%h valid=%b halted=%b, want 0 0000 0 0",
                     mem_req, mem_addr, dec_valid, halted);
        end
        checks++;
        if (dec_instr !== 24'h000000 || dec_len !== 2'd1 || dec_pc !== 16'h0000) begin
            errors++;
            $display("FAIL reset_dec: got instr=%h len=%0d pc=%h, want 000000 1 0000",
                     dec_instr, dec_len, dec_pc);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d want 0", perf_count);
        end
`endif
    endtask

    task automatic test_startup();
        clear_mem();
        mem_b[0] = 8'h3E; mem_b[1] = 8'h42; mem_b[2] = 8'h00;
        do_reset();
        dec_ready = 1'b1;
        step();  // cycle 1
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL start_fetch: got req=%b addr=%h, want 1 0000", mem_req, mem_addr);
        end
        step();  // cycle 2
        checks++;
        if (mem_req !== 1'b0 || dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_wait: got req=%b valid=%b, want 0 0", mem_req, dec_valid);
        end
        step();  // cycle 3
        checks++;
        if (dec_valid !== 1'b1 || dec_instr !== 24'h3E4200 || dec_len !== 2'd2 || dec_pc !== 16'h0000) begin
            errors++;
            $display("FAIL start_hold: got valid=%b instr=%h len=%0d pc=%h, want 1 3e4200 2 0000",
                     dec_valid, dec_instr, dec_len, dec_pc);
        end
        step();  // cycle 4
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0002) begin
            errors++;
            $display("FAIL start_next: got req=%b addr=%h, want 1 0002", mem_req, mem_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_pc  [3];
        logic [1:0]  exp_len [3];
        exp_pc[0] = 16'h0000; exp_len[0] = 2'd1;
        exp_pc[1] = 16'h0001; exp_len[1] = 2'd2;
        exp_pc[2] = 16'h0003; exp_len[2] = 2'd3;
        clear_mem();
        mem_b[0] = 8'h00;
        mem_b[1] = 8'hC6; mem_b[2] = 8'h05;
        mem_b[3] = 8'h21; mem_b[4] = 8'h34; mem_b[5] = 8'h12;
        do_reset();
        dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== exp_pc[i]) begin
                errors++;
                $display("FAIL seq_fetch%0d: got req=%b addr=%h, want 1 %h", i, mem_req, mem_addr, exp_pc[i]);
            end
            step();
            step();
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== exp_pc[i] || dec_len !== exp_len[i]) begin
                errors++;
                $display("FAIL seq_hold%0d: got valid=%b pc=%h len=%0d, want 1 %h %0d",
                         i, dec_valid, dec_pc, dec_len, exp_pc[i], exp_len[i]);
            end
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0006) begin
            errors++;
            $display("FAIL seq_next: got req=%b addr=%h, want 1 0006", mem_req, mem_addr);
        end
    endtask

    task automatic test_stall();
        int bad;
        clear_mem();
        mem_b[0] = 8'h3E; mem_b[1] = 8'h42; mem_b[2] = 8'h00;
        do_reset();
        dec_ready = 1'b0;
        step(); step(); step();  // cycle 3, HOLD
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (dec_valid !== 1'b1 || mem_req !== 1'b0 || dec_instr !== 24'h3E4200 ||
                dec_len !== 2'd2 || dec_pc !== 16'h0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d unstable cycles, want 0", bad);
        end
        dec_ready = 1'b1;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0002) begin
            errors++;
            $display("FAIL stall_release: got req=%b addr=%h, want 1 0002", mem_req, mem_addr);
        end
        dec_ready = 1'b0;
        step();
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 16'h0002) begin
            errors++;
            $display("FAIL stall_once: got req=%b addr=%h, want 0 0002", mem_req, mem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        clear_mem();
        mem_b[0] = 8'h3E; mem_b[1] = 8'h42;
        mem_b[16'h1234] = 8'h06; mem_b[16'h1235] = 8'h77;
        do_reset();
        dec_ready = 1'b1;
        step(); step();  // cycle 2, WAIT
        redir_valid = 1'b1;
        redir_pc    = 16'h1234;
        step();          // cycle 3
        redir_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h1234 || dec_valid !== 1'b0 || dec_instr !== 24'h000000) begin
            errors++;
            $display("FAIL rw_fetch: got req=%b addr=%h valid=%b instr=%h, want 1 1234 0 000000",
                     mem_req, mem_addr, dec_valid, dec_instr);
        end
        step(); step();
        checks++;
        if (dec_valid !== 1'b1 || dec_instr !== 24'h067700 || dec_pc !== 16'h1234 || dec_len !== 2'd2) begin
            errors++;
            $display("FAIL rw_hold: got valid=%b instr=%h pc=%h len=%0d, want 1 067700 1234 2",
                     dec_valid, dec_instr, dec_pc, dec_len);
        end
    endtask

    task automatic test_redirect_hold();
        clear_mem();
        mem_b[0] = 8'h3E; mem_b[1] = 8'h42;
        mem_b[16'h1234] = 8'hC3; mem_b[16'h1235] = 8'h00; mem_b[16'h1236] = 8'h20;
        do_reset();
        dec_ready = 1'b1;
        step(); step(); step();  // cycle 3, HOLD
        redir_valid = 1'b1;
        redir_pc    = 16'h1234;
        #1;
        checks++;
        if (dec_valid !== 1'b0) begin
            errors++;
            $display("FAIL rh_gate: got valid=%b want 0", dec_valid);
        end
        step();
        redir_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h1234) begin
            errors++;
            $display("FAIL rh_fetch: got req=%b addr=%h, want 1 1234", mem_req, mem_addr);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_count !== 32'd0) begin
            errors++;
            $display("FAIL rh_perf: got %0d want 0", perf_count);
        end
`endif
        step(); step();
        checks++;
        if (dec_valid !== 1'b1 || dec_instr !== 24'hC30020 || dec_pc !== 16'h1234 || dec_len !== 2'd3) begin
            errors++;
            $display("FAIL rh_hold: got valid=%b instr=%h pc=%h len=%0d, want 1 c30020 1234 3",
                     dec_valid, dec_instr, dec_pc, dec_len);
        end
    endtask

    task automatic test_halt();
        int bad;
        clear_mem();
        mem_b[16'h0010] = 8'h76;
        do_reset();
        dec_ready   = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 16'h0010;
        step();          // FETCH at 0x0010
        redir_valid = 1'b0;
        step(); step();  // HOLD
        checks++;
        if (dec_valid !== 1'b1 || dec_instr[23:16] !== 8'h76 || dec_len !== 2'd1 || dec_pc !== 16'h0010) begin
            errors++;
            $display("FAIL hlt_hold: got valid=%b instr=%h len=%0d pc=%h, want 1 76xxxx 1 0010",
                     dec_valid, dec_instr, dec_len, dec_pc);
        end
        step();
        checks++;
        if (halted !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 16'h0010) begin
            errors++;
            $display("FAIL hlt_enter: got halted=%b req=%b addr=%h, want 1 0 0010", halted, mem_req, mem_addr);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mem_req !== 1'b0 || halted !== 1'b1 || dec_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hlt_quiet: %0d active cycles, want 0", bad);
        end
        redir_valid = 1'b1;
        redir_pc    = 16'h0038;
        step();
        redir_valid = 1'b0;
        checks++;
        if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0038) begin
            errors++;
            $display("FAIL hlt_exit: got halted=%b req=%b addr=%h, want 0 1 0038", halted, mem_req, mem_addr);
        end
    endtask

    task automatic test_wrap();
        clear_mem();
        mem_b[16'hFFFE] = 8'h01; mem_b[16'hFFFF] = 8'hCD; mem_b[16'h0000] = 8'hAB;
        do_reset();
        dec_ready   = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 16'hFFFE;
        step();
        redir_valid = 1'b0;
        step(); step();
        checks++;
        if (dec_instr !== 24'h01CDAB || dec_len !== 2'd3 || dec_pc !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap_hold: got instr=%h len=%0d pc=%h, want 01cdab 3 fffe", dec_instr, dec_len, dec_pc);
        end
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_next: got req=%b addr=%h, want 1 0001", mem_req, mem_addr);
        end
    endtask

    task automatic test_len_decode();
        logic [7:0] ops  [24];
        logic [1:0] lens [24];
        logic [15:0] a;
        ops = '{8'h01, 8'h31, 8'h22, 8'h2A, 8'h3A, 8'hC3, 8'hCB, 8'hDA, 8'hF4, 8'hCD, 8'hFD, 8'hED,
                8'h06, 8'h3E, 8'h36, 8'hFE, 8'hDB, 8'hD3,
                8'h00, 8'hC9, 8'h40, 8'h02, 8'hE9, 8'hC1};
        lens = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3,
                 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        clear_mem();
        do_reset();
        dec_ready = 1'b0;
        for (int i = 0; i < 24; i++) begin
            a = 16'h0200 + 16'(i * 4);
            mem_b[a] = ops[i];
            redir_valid = 1'b1;
            redir_pc    = a;
            step();
            redir_valid = 1'b0;
            step(); step();
            checks++;
            if (dec_valid !== 1'b1 || dec_len !== lens[i] || dec_pc !== a) begin
                errors++;
                $display("FAIL len_%h: got valid=%b len=%0d pc=%h, want 1 %0d %h",
                         ops[i], dec_valid, dec_len, dec_pc, lens[i], a);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mem();
        do_reset();
        dec_ready = 1'b1;
        mem_b[0] = 8'h3E; mem_b[1] = 8'h42;
        // handshakes at edges 4, 7, 10 and 13
        repeat (13) step();
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_count !== 32'd4) begin
            errors++;
            $display("FAIL perf_four: got %0d want 4", perf_count);
        end
`endif
        redir_valid = 1'b1;
        redir_pc    = 16'h1234;
        step();
        redir_valid = 1'b0;
        checks++;
        if (mem_addr !== 16'h1234) begin
            errors++;
            $display("FAIL mid_redir: got addr=%h want 1234", mem_addr);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_count !== 32'd4) begin
            errors++;
            $display("FAIL perf_redir: got %0d want 4", perf_count);
        end
`endif
        step();  // WAIT
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 16'h0000 || dec_valid !== 1'b0 || dec_pc !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: got req=%b addr=%h valid=%b pc=%h, want 0 0000 0 0000",
                     mem_req, mem_addr, dec_valid, dec_pc);
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_count !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: got %0d want 0", perf_count);
        end
`endif
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        dec_ready   = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 16'h0000;
        mem_data    = 24'h000000;
        clear_mem();
        test_reset();
        test_startup();
        test_back_to_back();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_halt();
        test_wrap();
        test_len_decode();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multicycle instruction-fetch sequencer for the 8080 core. Owns the program counter, issues one memory read per instruction, decodes instruction length (1/2/3 bytes) from the opcode, and hands the assembled instruction to decode over a valid/ready handshake. Handles control-flow redirects from execute and HLT. Sits between the instruction port of `mem` and the decode stage.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_req`  out  1  read request, valid for the current cycle.
- `mem_addr`  out  16  read address; always equals the PC register.
- `mem_data`  in  24  read data: opcode [23:16], low byte [15:8], high byte [7:0]. Valid in the cycle after `mem_req`.
- `dec_valid`  out  1  instruction available to decode.
- `dec_ready`  in  1  decode accepts the instruction.
- `dec_instr`  out  24  captured instruction, same byte layout as `mem_data`.
- `dec_len`  out  2  instruction length: 1, 2 or 3.
- `dec_pc`  out  16  address of `dec_instr`.
- `redir_valid`  in  1  control-flow redirect (JMP/CALL/RET/RST/PCHL taken).
- `redir_pc`  in  16  redirect target.
- `halted`  out  1  core halted by HLT.
- `perf_count`  out  32  retired-instruction count. Present only with `FETCH_PERF_EN`.

## Operation
- States: IDLE, FETCH, WAIT, HOLD, HALTED. Reset state: IDLE, PC=`RESET_PC`.
- IDLE: go to FETCH unconditionally.
- FETCH: `mem_req`=1, `mem_addr`=PC. Go to WAIT.
- WAIT: capture `mem_data` into `dec_instr`, PC into `dec_pc`, and the decoded length into `dec_len`. Go to HOLD.
- HOLD: `dec_valid`=1. On handshake (`dec_valid`&`dec_ready`):
  - If the opcode is 0x76 (HLT), go to HALTED and leave PC unchanged.
  - Otherwise set PC to PC+`dec_len` and go to FETCH.
  - Without a handshake, stay in HOLD with all `dec_*` outputs stable.
- HALTED: `halted`=1 and no requests are issued. Only a redirect exits this state.
- Redirect: when `redir_valid` is high in any state, set PC to `redir_pc` and go to FETCH.
  - Redirect has priority over every other transition.
  - `dec_valid` is gated by `~redir_valid`, so a handshake can never coincide with a redirect.
  - Data returning for a request issued before the redirect is dropped, because it is captured only in WAIT.
- Length decode:
  - 3 bytes: 00rp0001 (LXI), 0x22, 0x2A, 0x32, 0x3A, 0xC3, 0xCB, 11ccc010 (Jccc), 11ccc100 (Cccc), 0xCD, 0xDD, 0xED, 0xFD.
  - 2 bytes: 00ddd110 (MVI), 0xC6, 0xCE, 0xD6, 0xDE, 0xE6, 0xEE, 0xF6, 0xFE, 0xD3, 0xDB.
  - 1 byte: all other opcodes.
- PC arithmetic is 16-bit modulo: 0xFFFF+1 = 0x0000 and 0xFFFE+3 = 0x0001.

## Timing
- Values during reset: `mem_req`=0, `mem_addr`=`RESET_PC`, `dec_valid`=0, `dec_instr`=0, `dec_len`=1, `dec_pc`=0, `halted`=0, `perf_count`=0.
- Reset asserted mid-operation: return to IDLE immediately (asynchronous). Any in-flight fetch is discarded.
- Startup, with edge 1 being the first posedge after `rst_n` rises:
  - Edge 1: IDLE→FETCH, so `mem_req`=1 in cycle 1.
  - Edge 2: →WAIT.
  - Edge 3: capture; `dec_valid`=1 in cycle 3.
- Throughput with `dec_ready` tied high: one instruction per 3 cycles (FETCH, WAIT, HOLD).
- Redirect sampled at edge N: FETCH at `redir_pc` in cycle N, `dec_valid` in cycle N+2.
- `mem_req`, `mem_addr`, `halted` and `dec_*` depend only on state and registers. The exception is `dec_valid`, which is also gated combinationally by `redir_valid`.

## Configuration
- `FETCH_PERF_EN` defined:
  - `perf_count` port exists.
  - The count increments by 1 on every handshake, HLT included, and wraps at 2^32.
  - Redirects and stalls do not count.
- `FETCH_PERF_EN` undefined: no port and no counter logic. All other behaviour is identical.

## Test plan
- Reset release, memory at 0x0000 = 0x3E 0x42 (MVI A,0x42), `dec_ready`=1 → `mem_req` in cycle 1 with addr 0x0000; `dec_valid` in cycle 3 with `dec_instr`=0x3E42xx, `dec_len`=2, `dec_pc`=0x0000; next fetch addr 0x0002.
- Instruction sequence 0x00, 0xC6 0x05, 0x21 0x34 0x12 → `dec_pc` = 0x0000, 0x0001, 0x0003 with `dec_len` = 1, 2, 3; next fetch addr 0x0006.
- `dec_ready` held low for 5 cycles in HOLD → `dec_valid` stays 1, `dec_*` stable, no `mem_req`; after release, PC advances exactly once.
- `redir_valid` with `redir_pc`=0x1234 in WAIT, and separately in HOLD with `dec_ready`=1 → old data dropped, no handshake in the redirect cycle, next fetch addr 0x1234.
- HLT (0x76) at 0x0010 accepted → `halted`=1, no `mem_req` for 10 cycles; then `redir_pc`=0x0038 → `halted`=0, fetch at 0x0038. PC wrap: LXI at 0xFFFE → next fetch addr 0x0001.
- With `FETCH_PERF_EN`: 4 handshakes plus 1 redirect → `perf_count`=4; assert `rst_n` mid-WAIT → `perf_count`=0, `mem_req`=0 immediately.
